fft_stage3: RTL and testbench

Final butterfly stage and output serializer of the 8-point FFT datapath; sits directly downstream of the stage-2 block and consumes its 16 registered outputs (cr0/ci0 … cr7/ci7). It performs the last four radix-2 butterflies on pairs (0,1), (2,3), (4,5), (6,7), with scaling, rounding and saturation. It undoes the bit-reversed output order and streams the eight bins X[0]..X[7] in natural order, one complex sample per cycle, under a valid/ready handshake.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_bf_scale.sv | 62 ++++++
 rtl/fft_stage3.sv | 176 +++++++++++++++++
 tb/tb_fft_stage3.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, state encoding and helpers for the FFT datapath stages.
package fft_pkg;

  localparam int unsigned W   = 16;
  localparam int unsigned NPT = 8;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BFLY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic         sat;
    logic [W-1:0] im;
    logic [W-1:0] re;
  } bin_t;

  // Bit-reversed index for an 8-point transform.
  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_bf_scale.sv
// One complex radix-2 butterfly (a+b, a-b) with round, shift and saturate.
module fft_bf_scale
  import fft_pkg::*;
#(
  parameter int unsigned SHIFT = 1
) (
  input  logic [W-1:0] a_re_i,
  input  logic [W-1:0] a_im_i,
  input  logic [W-1:0] b_re_i,
  input  logic [W-1:0] b_im_i,
  output logic [W-1:0] sum_re_o,
  output logic [W-1:0] sum_im_o,
  output logic         sum_sat_o,
  output logic [W-1:0] dif_re_o,
  output logic [W-1:0] dif_im_o,
  output logic         dif_sat_o
);

  localparam int unsigned WS = W + 1;
  // Two guard bits: the rounding add on a full-scale difference needs one more.
  localparam int unsigned WR = W + 2;
  localparam logic signed [WR-1:0] LIM_HI = $signed({2'b00, SAT_MAX});
  localparam logic signed [WR-1:0] LIM_LO = $signed({2'b11, SAT_MIN});

  // Returns {clipped, value} for one component.
  function automatic logic [W:0] scale_sat(input logic signed [WS-1:0] x);
    logic signed [WR-1:0] r;
    logic [W:0]           res;
    r = ($signed({x[WS-1], x}) + $signed({{(WR-1){1'b0}}, (SHIFT != 0)})) >>> SHIFT;
    if (r > LIM_HI) begin
      res = {1'b1, SAT_MAX};
    end else if (r < LIM_LO) begin
      res = {1'b1, SAT_MIN};
    end else begin
      res = {1'b0, r[W-1:0]};
    end
    return res;
  endfunction

  logic signed [WS-1:0] s_re, s_im, d_re, d_im;
  logic [W:0]           s_re_r, s_im_r, d_re_r, d_im_r;

  // Full-precision sum/difference, then per-component scaling.
  always_comb begin
    s_re   = $signed({a_re_i[W-1], a_re_i}) + $signed({b_re_i[W-1], b_re_i});
    s_im   = $signed({a_im_i[W-1], a_im_i}) + $signed({b_im_i[W-1], b_im_i});
    d_re   = $signed({a_re_i[W-1], a_re_i}) - $signed({b_re_i[W-1], b_re_i});
    d_im   = $signed({a_im_i[W-1], a_im_i}) - $signed({b_im_i[W-1], b_im_i});
    s_re_r = scale_sat(s_re);
    s_im_r = scale_sat(s_im);
    d_re_r = scale_sat(d_re);
    d_im_r = scale_sat(d_im);
  end

  assign sum_re_o  = s_re_r[W-1:0];
  assign sum_im_o  = s_im_r[W-1:0];
  assign sum_sat_o = s_re_r[W] | s_im_r[W];
  assign dif_re_o  = d_re_r[W-1:0];
  assign dif_im_o  = d_im_r[W-1:0];
  assign dif_sat_o = d_re_r[W] | d_im_r[W];

endmodule

// File: rtl/fft_stage3.sv
// Final FFT butterfly stage: four scaled butterflies, bit-reverse reorder and
// a natural-order serializer with valid/ready handshake.
module fft_stage3
  import fft_pkg::*;
#(
  parameter int unsigned SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] cr0,
  input  logic [W-1:0] cr1,
  input  logic [W-1:0] cr2,
  input  logic [W-1:0] cr3,
  input  logic [W-1:0] cr4,
  input  logic [W-1:0] cr5,
  input  logic [W-1:0] cr6,
  input  logic [W-1:0] cr7,
  input  logic [W-1:0] ci0,
  input  logic [W-1:0] ci1,
  input  logic [W-1:0] ci2,
  input  logic [W-1:0] ci3,
  input  logic [W-1:0] ci4,
  input  logic [W-1:0] ci5,
  input  logic [W-1:0] ci6,
  input  logic [W-1:0] ci7,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [2:0]   out_idx,
  output logic         out_last,
  output logic         out_sat
);

  localparam logic [2:0] IDX_LAST = 3'(NPT - 1);

  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d, idx_inc;
  logic       accept, load_res;

  logic [W-1:0] in_re_q [NPT];
  logic [W-1:0] in_im_q [NPT];
  bin_t         res_q   [NPT];
  bin_t         bin_nat [NPT];

  logic [NPT-1:0][W-1:0] d_re, d_im;
  logic [NPT-1:0]        d_sat;

  bin_t out_q, out_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;

  assign in_ready = (state_q == IDLE) |
                    ((state_q == DRAIN) & (idx_q == IDX_LAST) & out_ready);
  assign accept   = in_valid & in_ready;
  assign idx_inc  = idx_q + 3'd1;

  // Four butterflies on adjacent pairs of the captured frame.
  for (genvar m = 0; m < NPT / 2; m++) begin : g_bf
    fft_bf_scale #(.SHIFT(SHIFT)) u_bf (
      .a_re_i   (in_re_q[2*m]),
      .a_im_i   (in_im_q[2*m]),
      .b_re_i   (in_re_q[2*m+1]),
      .b_im_i   (in_im_q[2*m+1]),
      .sum_re_o (d_re[2*m]),
      .sum_im_o (d_im[2*m]),
      .sum_sat_o(d_sat[2*m]),
      .dif_re_o (d_re[2*m+1]),
      .dif_im_o (d_im[2*m+1]),
      .dif_sat_o(d_sat[2*m+1])
    );
  end

  // Undo bit-reversed order: X[k] = d[bitrev3(k)].
  always_comb begin
    for (int k = 0; k < NPT; k++) begin
      bin_nat[k].re  = d_re[bitrev3(3'(k))];
      bin_nat[k].im  = d_im[bitrev3(3'(k))];
      bin_nat[k].sat = d_sat[bitrev3(3'(k))];
    end
  end

  // Next-state, beat index and output register loading.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_res    = 1'b0;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = BFLY;
      end
      BFLY: begin
        state_d     = DRAIN;
        idx_d       = '0;
        load_res    = 1'b1;
        out_valid_d = 1'b1;
        out_d       = bin_nat[0];
        out_last_d  = 1'b0;
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_d       = '0;
            out_last_d  = 1'b0;
            state_d     = accept ? BFLY : IDLE;
          end else begin
            idx_d      = idx_inc;
            out_d      = res_q[idx_inc];
            out_last_d = (idx_inc == IDX_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Input frame capture on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPT; k++) begin
        in_re_q[k] <= '0;
        in_im_q[k] <= '0;
      end
    end else if (accept) begin
      in_re_q[0] <= cr0; in_im_q[0] <= ci0;
      in_re_q[1] <= cr1; in_im_q[1] <= ci1;
      in_re_q[2] <= cr2; in_im_q[2] <= ci2;
      in_re_q[3] <= cr3; in_im_q[3] <= ci3;
      in_re_q[4] <= cr4; in_im_q[4] <= ci4;
      in_re_q[5] <= cr5; in_im_q[5] <= ci5;
      in_re_q[6] <= cr6; in_im_q[6] <= ci6;
      in_re_q[7] <= cr7; in_im_q[7] <= ci7;
    end
  end

  // Natural-order result buffer, written in the butterfly cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPT; k++) res_q[k] <= '0;
    end else if (load_res) begin
      for (int k = 0; k < NPT; k++) res_q[k] <= bin_nat[k];
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_q.re;
  assign out_im    = out_q.im;
  assign out_sat   = out_q.sat;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_stage3.sv
// Directed bench for fft_stage3: hand-computed bins, backpressure,
// back-to-back frames and asynchronous reset mid-stream.
module tb_fft_stage3;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic        out_valid, out_ready, out_last, out_sat;
  logic [15:0] out_re, out_im;
  logic [2:0]  out_idx;
  logic [15:0] fr_re [8];
  logic [15:0] fr_im [8];

  int exp_re [16];
  int exp_im [16];
  int exp_sat[16];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc, first_cyc, acc2_cyc, idx0b_cyc, last_cyc;

  always #5 clk = ~clk;

  fft_stage3 #(.SHIFT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cr0(fr_re[0]), .cr1(fr_re[1]), .cr2(fr_re[2]), .cr3(fr_re[3]),
    .cr4(fr_re[4]), .cr5(fr_re[5]), .cr6(fr_re[6]), .cr7(fr_re[7]),
    .ci0(fr_im[0]), .ci1(fr_im[1]), .ci2(fr_im[2]), .ci3(fr_im[3]),
    .ci4(fr_im[4]), .ci5(fr_im[5]), .ci6(fr_im[6]), .ci7(fr_im[7]),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_sat  (out_sat)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 8; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) begin
      exp_re[i]  = 0;
      exp_im[i]  = 0;
      exp_sat[i] = 0;
    end
  endtask

  // Frame F4: X3 = d6, X7 = d7, both non-zero.
  task automatic load_f4();
    clear_frame();
    fr_re[6] = 16'(1000);
    fr_re[7] = 16'(-3);
    fr_im[6] = 16'(7);
    fr_im[7] = 16'(5);
  endtask

  task automatic exp_f4(input int base);
    exp_re[base+3] = 499;  exp_im[base+3] = 6;
    exp_re[base+7] = 502;  exp_im[base+7] = 1;
  endtask

  // Present the frame and return just after the accepting edge.
  task automatic start_frame();
    int g = 0;
    in_valid = 1'b1;
    while (!in_ready && g < 40) begin
      step();
      g++;
    end
    chk("accept_ready", int'(in_ready), 1);
    acc_cyc = cyc;
    step();
  endtask

  // Consume nbeats output beats, optionally stalling at one beat.
  task automatic collect(input int nbeats, input int stall_at, input int stall_len);
    int n = 0;
    int g = 0;
    int stl = 0;
    first_cyc = -1;
    while (n < nbeats && g < 60) begin
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (n == 8 && in_valid) begin
          in_valid  = 1'b0;
          idx0b_cyc = cyc;
        end
        if (n == stall_at && stl < stall_len) begin
          out_ready = 1'b0;
          chk($sformatf("stall%0d_idx", stl), int'(out_idx), n % 8);
          chk($sformatf("stall%0d_re", stl), $signed(out_re), exp_re[n]);
          chk($sformatf("stall%0d_in_ready", stl), int'(in_ready), 0);
          stl++;
        end else begin
          out_ready = 1'b1;
          chk($sformatf("beat%0d_idx", n), int'(out_idx), n % 8);
          chk($sformatf("beat%0d_re", n), $signed(out_re), exp_re[n]);
          chk($sformatf("beat%0d_im", n), $signed(out_im), exp_im[n]);
          chk($sformatf("beat%0d_sat", n), int'(out_sat), exp_sat[n]);
          chk($sformatf("beat%0d_last", n), int'(out_last), int'((n % 8) == 7));
          if (nbeats == 16 && n == 7) begin
            chk("b2b_in_ready_idx7", int'(in_ready), 1);
            acc2_cyc = cyc;
          end
          if (n == nbeats - 1) last_cyc = cyc;
          n++;
        end
      end
      step();
      g++;
    end
    chk("beats_seen", n, nbeats);
  endtask

  task automatic run_single(input int stall_at, input int stall_len);
    start_frame();
    in_valid = 1'b0;
    chk("bfly_no_valid", int'(out_valid), 0);
    collect(8, stall_at, stall_len);
    chk("latency", first_cyc - acc_cyc, 2);
    chk("post_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int g;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clear_frame();
    clear_exp();
    repeat (3) step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_re", $signed(out_re), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    rst = 1'b1;
    step();
    chk("rst_in_ready", int'(in_ready), 1);

    // Basic: 200,100 -> X0=(300+1)>>>1=150, X4=(100+1)>>>1=50
    clear_frame(); clear_exp();
    fr_re[0] = 16'(200); fr_re[1] = 16'(100);
    exp_re[0] = 150; exp_re[4] = 50;
    run_single(-1, 0);

    // Rounding: 201,100 -> 151 and 51
    clear_frame(); clear_exp();
    fr_re[0] = 16'(201); fr_re[1] = 16'(100);
    exp_re[0] = 151; exp_re[4] = 51;
    run_single(-1, 0);

    // Saturation and bit-reverse placement
    clear_frame(); clear_exp();
    fr_re[2] = 16'(32767); fr_re[3] = 16'h8000;
    fr_im[4] = 16'(-1000); fr_im[5] = 16'(1000);
    exp_re[6] = 32767; exp_sat[6] = 1;
    exp_im[5] = -1000;
    run_single(-1, 0);

    // Backpressure: three stall cycles at idx3
    load_f4(); clear_exp(); exp_f4(0);
    run_single(3, 3);

    // Back-to-back: F1 then F4 with in_valid held high
    clear_frame(); clear_exp();
    fr_re[0] = 16'(200); fr_re[1] = 16'(100);
    exp_re[0] = 150; exp_re[4] = 50;
    exp_f4(8);
    start_frame();
    load_f4();
    collect(16, -1, 0);
    chk("b2b_first_latency", first_cyc - acc_cyc, 2);
    chk("b2b_second_accept", acc2_cyc - acc_cyc, 9);
    chk("b2b_second_idx0", idx0b_cyc - acc2_cyc, 2);
    chk("b2b_total_cycles", last_cyc - acc_cyc, 18);
    chk("b2b_post_valid", int'(out_valid), 0);

    // Reset at idx4 of a streaming frame
    clear_frame(); clear_exp();
    fr_re[0] = 16'(200); fr_re[1] = 16'(100);
    start_frame();
    in_valid = 1'b0;
    g = 0;
    while (!(out_valid && out_idx == 3'd4) && g < 20) begin
      step();
      g++;
    end
    chk("rst_reach_idx4", int'(out_idx), 4);
    chk("rst_pre_re", $signed(out_re), 50);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_re", $signed(out_re), 0);
    chk("arst_out_im", $signed(out_im), 0);
    chk("arst_out_idx", int'(out_idx), 0);
    chk("arst_out_last", int'(out_last), 0);
    chk("arst_out_sat", int'(out_sat), 0);
    #2 rst = 1'b1;
    step();
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_idle_valid", int'(out_valid), 0);

    clear_frame(); clear_exp();
    fr_re[0] = 16'(201); fr_re[1] = 16'(100);
    exp_re[0] = 151; exp_re[4] = 51;
    run_single(-1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
